datamem_dump_ctrl: RTL and testbench
====================================

Name: datamem_dump_ctrl

Overview:
Sequences the data memory's debug read port so the debug unit can dump data memory contents. On request it reads a contiguous range of words starting at word 0. It serializes each 32-bit word into bytes on a valid/ready byte stream toward the debug UART transmitter. The block sits between the debug unit FSM and the memory-access stage's debug address, read-enable and data pins. It is only started while the pipeline is halted.

Parameters:
NB_REG, 32, data memory word width in bits; must be a multiple of NB_BYTE
NB_BYTE, 8, width of one transmitted byte
NB_DBG_ADDR, 16, width of the debug memory address (word index)
N_ADDR, 2048, data memory depth in words; upper clamp for the dump length

Ports:
i_clock  in  1  clock
i_reset  in  1  synchronous active-high reset
i_start  in  1  one-cycle dump request; ignored unless state is IDLE
i_n_words  in  NB_DBG_ADDR  number of words to dump; sampled on an accepted i_start
i_abort  in  1  aborts the dump; state returns to IDLE next cycle and no o_done is issued
o_debug_datamem_addr  out  NB_DBG_ADDR  word address driven to the data memory debug port
o_debug_datamem_re  out  1  debug port read enable
i_debug_datamem_data  in  NB_REG  debug port read data; valid 1 cycle after o_debug_datamem_re
o_tx_data  out  NB_BYTE  byte to transmit
o_tx_valid  out  1  o_tx_data is valid
i_tx_ready  in  1  consumer accepts the byte when o_tx_valid and i_tx_ready are both high
o_busy  out  1  high in every state except IDLE
o_done  out  1  one-cycle pulse after the last byte of a dump is accepted

Behaviour:
- Reset: state IDLE; all outputs 0, including the address, word counter and byte counter.
- Length: on an accepted i_start, latch len = min(i_n_words, N_ADDR).
  - len == 0: go to DONE directly; no reads and no bytes.
- States: IDLE, READ, WAIT, SEND, DONE.
- IDLE: o_busy = 0. i_start moves to READ with addr = 0 (or to DONE if len == 0).
- READ: o_debug_datamem_re = 1 for exactly one cycle with the current addr; next state WAIT.
- WAIT: capture i_debug_datamem_data into the word shift register; clear byte_cnt; next state SEND.
- SEND:
  - o_tx_valid = 1; o_tx_data = shift register MSB byte first, i.e. bits [NB_REG-1 -: NB_BYTE].
  - On a handshake: shift the register left by NB_BYTE and increment byte_cnt.
  - After handshake number NB_REG/NB_BYTE: if addr == len-1 go to DONE; otherwise addr += 1 and go to READ.
  - o_tx_data and o_tx_valid hold steady while i_tx_ready is low.
- DONE: o_done = 1 for one cycle; next state IDLE; o_busy = 1 in this state.
- Timing with i_tx_ready tied high: each word takes 2 + 4 = 6 cycles. o_done rises 1 cycle after the final handshake.
- o_debug_datamem_re is 0 outside READ. o_debug_datamem_addr is registered and holds its value between reads.
- i_abort has priority over every transition except i_reset. In IDLE it has no effect.
- i_start arriving while busy is ignored and does not restart the dump.
- i_reset mid-dump: immediate return to the reset state; a partial byte is dropped and o_tx_valid is 0 the next cycle.
- The address never exceeds len-1. No wrap-around is possible because len <= N_ADDR.

Test Plan:
- Memory preloaded with word0 = 0x11223344 and word1 = 0xAABBCCDD; i_n_words = 2; i_tx_ready = 1.
  -> Bytes 11,22,33,44,AA,BB,CC,DD, in that order.
  -> re pulses at addr 0 and addr 1.
  -> o_done fires 12 cycles after start acceptance; o_busy is high throughout.
- Same preload, i_tx_ready toggling 1-0-0-1 with random stalls.
  -> Identical byte sequence; o_tx_data is stable during every stall; no duplicated or lost bytes.
- i_n_words = 0.
  -> No re pulse and no o_tx_valid; o_done pulses 1 cycle after start.
- i_n_words = 0xFFFF with N_ADDR = 2048.
  -> Exactly 2048 reads and 8192 bytes; the last address is 0x07FF; then o_done.
- i_abort asserted during SEND of word 3's second byte.
  -> Next cycle: state IDLE, o_tx_valid = 0, o_busy = 0, no o_done.
  -> A subsequent i_start with i_n_words = 1 restarts cleanly from addr 0.
- i_start re-pulsed mid-dump, then i_reset mid-WAIT.
  -> The re-pulse is ignored.
  -> The reset zeroes all outputs the cycle after assertion.

Source files
------------

// File: rtl/datamem_dump_ctrl.sv
// Data memory dump sequencer for the debug unit.
// Reads words 0..len-1 through the data memory debug port and streams each
// word MSB byte first on a valid/ready byte interface toward the debug UART.
//
// Ports:
//   i_clock, i_reset          clock, synchronous active-high reset
//   i_start, i_n_words        dump request (IDLE only) and requested word count
//   i_abort                   drop the dump, back to IDLE without o_done
//   o_debug_datamem_addr/_re  debug read port address and read enable
//   i_debug_datamem_data      debug read data, valid one cycle after the read enable
//   o_tx_data/_valid, i_tx_ready   byte stream toward the transmitter
//   o_busy, o_done            activity flag and end-of-dump pulse
module datamem_dump_ctrl #(
    parameter int unsigned NB_REG      = 32,
    parameter int unsigned NB_BYTE     = 8,
    parameter int unsigned NB_DBG_ADDR = 16,
    parameter int unsigned N_ADDR      = 2048
) (
    input  logic                   i_clock,
    input  logic                   i_reset,
    input  logic                   i_start,
    input  logic [NB_DBG_ADDR-1:0] i_n_words,
    input  logic                   i_abort,
    output logic [NB_DBG_ADDR-1:0] o_debug_datamem_addr,
    output logic                   o_debug_datamem_re,
    input  logic [NB_REG-1:0]      i_debug_datamem_data,
    output logic [NB_BYTE-1:0]     o_tx_data,
    output logic                   o_tx_valid,
    input  logic                   i_tx_ready,
    output logic                   o_busy,
    output logic                   o_done
);

    localparam int unsigned N_BYTES = NB_REG / NB_BYTE;
    localparam int unsigned BCW     = (N_BYTES > 1) ? $clog2(N_BYTES) : 1;
    localparam logic [NB_DBG_ADDR-1:0] MAX_LEN   = NB_DBG_ADDR'(N_ADDR);
    localparam logic [BCW-1:0]         LAST_BYTE = BCW'(N_BYTES - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_WAIT,
        ST_SEND,
        ST_DONE
    } state_t;

    state_t                 state_q, state_d;
    logic [NB_DBG_ADDR-1:0] addr_q, addr_d;
    logic [NB_DBG_ADDR-1:0] last_q, last_d;     // len-1, final word address
    logic [NB_REG-1:0]      shift_q, shift_d;
    logic [BCW-1:0]         byte_cnt_q, byte_cnt_d;
    logic                   re_q, valid_q, busy_q, done_q;
    logic [NB_DBG_ADDR-1:0] len_c;

    // Requested length clamped to the memory depth
    assign len_c = (i_n_words > MAX_LEN) ? MAX_LEN : i_n_words;

    // State and datapath registers; status flags decode the next state so
    // they line up with the state they describe.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            last_q     <= '0;
            shift_q    <= '0;
            byte_cnt_q <= '0;
            re_q       <= 1'b0;
            valid_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            last_q     <= last_d;
            shift_q    <= shift_d;
            byte_cnt_q <= byte_cnt_d;
            re_q       <= (state_d == ST_READ);
            valid_q    <= (state_d == ST_SEND);
            busy_q     <= (state_d != ST_IDLE);
            done_q     <= (state_d == ST_DONE);
        end
    end

    // Next-state and datapath update
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        last_d     = last_q;
        shift_d    = shift_q;
        byte_cnt_d = byte_cnt_q;

        if (i_abort && (state_q != ST_IDLE)) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (i_start) begin
                        addr_d = '0;
                        if (len_c == '0) begin
                            state_d = ST_DONE;
                        end else begin
                            last_d  = len_c - NB_DBG_ADDR'(1);
                            state_d = ST_READ;
                        end
                    end
                end
                ST_READ: state_d = ST_WAIT;
                ST_WAIT: begin
                    shift_d    = i_debug_datamem_data;
                    byte_cnt_d = '0;
                    state_d    = ST_SEND;
                end
                ST_SEND: begin
                    if (i_tx_ready) begin
                        shift_d    = shift_q << NB_BYTE;
                        byte_cnt_d = byte_cnt_q + BCW'(1);
                        if (byte_cnt_q == LAST_BYTE) begin
                            if (addr_q == last_q) begin
                                state_d = ST_DONE;
                            end else begin
                                addr_d  = addr_q + NB_DBG_ADDR'(1);
                                state_d = ST_READ;
                            end
                        end
                    end
                end
                ST_DONE: state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    assign o_debug_datamem_addr = addr_q;
    assign o_debug_datamem_re   = re_q;
    assign o_tx_data            = shift_q[NB_REG-1 -: NB_BYTE];
    assign o_tx_valid           = valid_q;
    assign o_busy               = busy_q;
    assign o_done               = done_q;

endmodule

// File: tb/tb_datamem_dump_ctrl.sv
// Scoreboard bench for datamem_dump_ctrl: a behavioural data memory answers
// debug reads, expected addresses and bytes are queued when a dump starts
// and retired by monitors on the falling edge.
module tb_datamem_dump_ctrl;

    localparam int unsigned NB_REG      = 32;
    localparam int unsigned NB_BYTE     = 8;
    localparam int unsigned NB_DBG_ADDR = 16;
    localparam int unsigned N_ADDR      = 2048;

    logic                   i_clock = 1'b0;
    logic                   i_reset = 1'b1;
    logic                   i_start = 1'b0;
    logic [NB_DBG_ADDR-1:0] i_n_words = '0;
    logic                   i_abort = 1'b0;
    logic [NB_DBG_ADDR-1:0] o_debug_datamem_addr;
    logic                   o_debug_datamem_re;
    logic [NB_REG-1:0]      i_debug_datamem_data = '0;
    logic [NB_BYTE-1:0]     o_tx_data;
    logic                   o_tx_valid;
    logic                   i_tx_ready = 1'b1;
    logic                   o_busy;
    logic                   o_done;

    datamem_dump_ctrl #(
        .NB_REG(NB_REG), .NB_BYTE(NB_BYTE), .NB_DBG_ADDR(NB_DBG_ADDR), .N_ADDR(N_ADDR)
    ) dut (
        .i_clock(i_clock), .i_reset(i_reset), .i_start(i_start), .i_n_words(i_n_words),
        .i_abort(i_abort), .o_debug_datamem_addr(o_debug_datamem_addr),
        .o_debug_datamem_re(o_debug_datamem_re), .i_debug_datamem_data(i_debug_datamem_data),
        .o_tx_data(o_tx_data), .o_tx_valid(o_tx_valid), .i_tx_ready(i_tx_ready),
        .o_busy(o_busy), .o_done(o_done)
    );

    always #5 i_clock = ~i_clock;

    logic [NB_REG-1:0] mem [0:N_ADDR-1];
    always @(posedge i_clock)
        if (o_debug_datamem_re) i_debug_datamem_data <= mem[o_debug_datamem_addr[10:0]];

    int cyc = 0;
    always @(posedge i_clock) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;
    int n_reads = 0, n_bytes = 0, n_done = 0, done_cyc = 0;
    int start_cyc = 0;
    logic [NB_DBG_ADDR-1:0] last_addr = '0;
    int rdy_mode = 0;
    int rk = 0;

    logic [NB_DBG_ADDR-1:0] exp_addr_q [$];
    logic [NB_BYTE-1:0]     exp_byte_q [$];

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s got %h want %h", tag, act, exp);
        end
    endtask

    // Ready driver: tied high, or 1-0-0-1 followed by random stalls
    initial forever begin
        @(posedge i_clock);
        #1;
        if (rdy_mode == 0) begin
            i_tx_ready = 1'b1;
        end else begin
            if (rk < 4) i_tx_ready = (rk == 1 || rk == 2) ? 1'b0 : 1'b1;
            else        i_tx_ready = 1'($urandom_range(0, 1));
            rk++;
        end
    end

    // Monitors: read addresses, byte stream (every presented cycle) and done
    always @(negedge i_clock) begin
        if (o_debug_datamem_re) begin
            n_reads++;
            last_addr = o_debug_datamem_addr;
            if (exp_addr_q.size() == 0) check_eq("re_spurious", 1, 0);
            else check_eq("re_addr", 32'(o_debug_datamem_addr), 32'(exp_addr_q.pop_front()));
        end
        if (o_tx_valid) begin
            if (exp_byte_q.size() == 0) begin
                check_eq("tx_spurious", 1, 0);
            end else begin
                check_eq("tx_data", 32'(o_tx_data), 32'(exp_byte_q[0]));
                if (i_tx_ready) begin
                    void'(exp_byte_q.pop_front());
                    n_bytes++;
                end
            end
        end
        if (o_done) begin
            n_done++;
            done_cyc = cyc;
        end
    end

    // Queue the expected reads/bytes and pulse i_start; entered just after a posedge
    task automatic kick(input int n);
        int len;
        logic [NB_REG-1:0] w;
        len = (n > int'(N_ADDR)) ? int'(N_ADDR) : n;
        for (int a = 0; a < len; a++) begin
            exp_addr_q.push_back(NB_DBG_ADDR'(a));
            w = mem[a];
            for (int b = 0; b < 4; b++) exp_byte_q.push_back(w[31 - 8*b -: 8]);
        end
        i_n_words = NB_DBG_ADDR'(n);
        i_start   = 1'b1;
        @(posedge i_clock);
        #1;
        i_start   = 1'b0;
        start_cyc = cyc;
    endtask

    task automatic run_dump(input int n, input int mode, input int exp_lat);
        int d0, r0, b0, gaps, len;
        len = (n > int'(N_ADDR)) ? int'(N_ADDR) : n;
        rdy_mode = mode;
        rk = 0;
        d0 = n_done; r0 = n_reads; b0 = n_bytes; gaps = 0;
        kick(n);
        for (int k = 0; k < 20000; k++) begin
            @(negedge i_clock);
            #1;
            if (n_done != d0) break;
            if (!o_busy) gaps++;
        end
        if (n_done == d0) check_eq("done_timeout", 0, 1);
        if (exp_lat >= 0) check_eq("done_latency", 32'(done_cyc - start_cyc), 32'(exp_lat));
        check_eq("busy_gaps", 32'(gaps), 0);
        check_eq("n_reads", 32'(n_reads - r0), 32'(len));
        check_eq("n_bytes", 32'(n_bytes - b0), 32'(4 * len));
        check_eq("addr_q_empty", 32'(exp_addr_q.size()), 0);
        check_eq("byte_q_empty", 32'(exp_byte_q.size()), 0);
        @(negedge i_clock);
        check_eq("done_one_cycle", 32'(o_done), 0);
        check_eq("idle_busy", 32'(o_busy), 0);
        rdy_mode = 0;
        @(posedge i_clock);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_addr"},  32'(o_debug_datamem_addr), 0);
        check_eq({tag, "_re"},    32'(o_debug_datamem_re), 0);
        check_eq({tag, "_data"},  32'(o_tx_data), 0);
        check_eq({tag, "_valid"}, 32'(o_tx_valid), 0);
        check_eq({tag, "_busy"},  32'(o_busy), 0);
        check_eq({tag, "_done"},  32'(o_done), 0);
    endtask

    initial begin : stim
        int d0, b0, found;
        for (int a = 0; a < int'(N_ADDR); a++) mem[a] = $urandom;
        mem[0] = 32'h11223344;
        mem[1] = 32'hAABBCCDD;

        repeat (3) @(posedge i_clock);
        @(negedge i_clock);
        check_all_zero("reset");
        @(posedge i_clock);
        #1;
        i_reset = 1'b0;
        @(posedge i_clock);
        #1;

        // Two words, ready tied high
        run_dump(2, 0, 12);
        // Same words with stalls
        run_dump(2, 1, -1);
        // Zero length: done one cycle after start, no reads/bytes
        run_dump(0, 0, 0);
        // Oversized request clamps to full depth
        run_dump(16'hFFFF, 0, 6 * int'(N_ADDR));
        check_eq("last_addr", 32'(last_addr), 32'h7FF);

        // Abort while word 3 byte 1 is on the stream
        d0 = n_done; b0 = n_bytes; found = 0;
        kick(8);
        for (int k = 0; k < 200; k++) begin
            @(negedge i_clock);
            #1;
            if (o_tx_valid && (n_bytes - b0 == 14)) begin
                found = 1;
                break;
            end
        end
        check_eq("abort_reached", 32'(found), 1);
        check_eq("abort_addr", 32'(o_debug_datamem_addr), 3);
        i_abort = 1'b1;
        @(posedge i_clock);
        #1;
        i_abort = 1'b0;
        @(negedge i_clock);
        check_eq("abort_valid", 32'(o_tx_valid), 0);
        check_eq("abort_busy", 32'(o_busy), 0);
        check_eq("abort_re", 32'(o_debug_datamem_re), 0);
        exp_addr_q.delete();
        exp_byte_q.delete();
        repeat (4) @(posedge i_clock);
        #1;
        check_eq("abort_no_done", 32'(n_done), 32'(d0));
        run_dump(1, 0, 6);

        // Start re-pulsed mid-dump is ignored; reset during WAIT clears everything
        kick(4);
        repeat (3) @(posedge i_clock);
        #1;
        i_n_words = 16'd1;
        i_start   = 1'b1;
        @(posedge i_clock);
        #1;
        i_start = 1'b0;
        found = 0;
        for (int k = 0; k < 50; k++) begin
            @(negedge i_clock);
            #1;
            if (o_debug_datamem_re && o_debug_datamem_addr == 16'd1) begin
                found = 1;
                break;
            end
        end
        check_eq("repulse_word1_read", 32'(found), 1);
        check_eq("repulse_bytes_left", 32'(exp_byte_q.size()), 12);
        @(posedge i_clock);
        #1;
        i_reset = 1'b1;
        @(negedge i_clock);
        check_eq("wait_before_reset_valid", 32'(o_tx_valid), 0);
        @(negedge i_clock);
        check_all_zero("midreset");
        exp_addr_q.delete();
        exp_byte_q.delete();
        @(posedge i_clock);
        #1;
        i_reset = 1'b0;
        @(posedge i_clock);
        #1;
        run_dump(1, 0, 6);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
